irq_dispatch_decoder: RTL and testbench

Registered index-to-one-hot dispatcher that consumes the encoded index/valid pair produced by the priority encoder and drives a one-hot request to the selected line. Each request is held until that line acknowledges it or a timeout expires. It sits on the consumer side of the interrupt path, between the encoder output and the per-source handlers, and exposes a valid/ready handshake upstream.

---
 rtl/irq_dispatch_decoder.sv | 102 ++++++++++
 tb/tb_irq_dispatch_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/irq_dispatch_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | irq_dispatch_decoder: index/valid to held one-hot request, ack/timeout |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module irq_dispatch_decoder #(
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [IDX_W-1:0]      in_idx,
  output logic                  in_ready,
  output logic [2**IDX_W-1:0]   req_onehot,
  output logic                  req_valid,
  input  logic [2**IDX_W-1:0]   ack,
  output logic                  timeout_err,
  output logic                  spurious_ack,
  output logic [CNT_W-1:0]      done_cnt
);

  localparam int N = 2**IDX_W;
  localparam int TIMER_W = 8;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t               state, state_d;
  logic [IDX_W-1:0]     sel, sel_d;
  logic [TIMER_W-1:0]   timer, timer_d;
  logic [N-1:0]         onehot_d;
  logic                 valid_d;
  logic                 terr_d;
  logic                 spur_d;
  logic [CNT_W-1:0]     done_d;

  assign in_ready = (state == IDLE);

  always_comb begin
    state_d  = state;
    sel_d    = sel;
    timer_d  = timer;
    onehot_d = req_onehot;
    valid_d  = req_valid;
    terr_d   = 1'b0;
    spur_d   = 1'b0;
    done_d   = done_cnt;
    if (state == IDLE) begin
      if (in_valid) begin
        state_d  = PEND;
        sel_d    = in_idx;
        timer_d  = '0;
        onehot_d = ONE << in_idx;
        valid_d  = 1'b1;
      end
    end else begin
      timer_d = timer + 8'd1;
      // req_onehot holds exactly the selected bit, so its complement masks the rest
      spur_d  = |(ack & ~req_onehot);
      if (ack[sel]) begin
        state_d  = IDLE;
        timer_d  = '0;
        onehot_d = '0;
        valid_d  = 1'b0;
        done_d   = done_cnt + CNT_W'(1);
      end else if (timer == LAST_TICK) begin
        state_d  = IDLE;
        timer_d  = '0;
        onehot_d = '0;
        valid_d  = 1'b0;
        terr_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sel          <= '0;
      timer        <= '0;
      req_onehot   <= '0;
      req_valid    <= 1'b0;
      timeout_err  <= 1'b0;
      spurious_ack <= 1'b0;
      done_cnt     <= '0;
    end else begin
      state        <= state_d;
      sel          <= sel_d;
      timer        <= timer_d;
      req_onehot   <= onehot_d;
      req_valid    <= valid_d;
      timeout_err  <= terr_d;
      spurious_ack <= spur_d;
      done_cnt     <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_dispatch_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_irq_dispatch_decoder: directed stimulus, cycle-level reference model |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_irq_dispatch_decoder;

  localparam int IDX_W   = 2;
  localparam int N       = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [IDX_W-1:0] in_idx = '0;
  logic             in_ready;
  logic [N-1:0]     req_onehot;
  logic             req_valid;
  logic [N-1:0]     ack = '0;
  logic             timeout_err;
  logic             spurious_ack;
  logic [CNT_W-1:0] done_cnt;

  int passed = 0;
  int total  = 0;

  irq_dispatch_decoder #(.IDX_W(IDX_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_idx(in_idx),
    .in_ready(in_ready), .req_onehot(req_onehot), .req_valid(req_valid),
    .ack(ack), .timeout_err(timeout_err), .spurious_ack(spurious_ack),
    .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // Reference: a pending request is just (line, deadline edge); outcomes follow from the rules.
  bit m_pend = 0;
  int m_sel = 0;
  int m_deadline = 0;
  int m_done = 0;
  bit m_terr = 0;
  bit m_spur = 0;
  int cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0; m_done = 0; m_terr = 0; m_spur = 0;
    end else begin
      cyc++;
      m_terr = 0;
      m_spur = 0;
      if (!m_pend) begin
        if (in_valid) begin
          m_pend = 1;
          m_sel = int'(in_idx);
          m_deadline = cyc + TIMEOUT;
        end
      end else begin
        for (int b = 0; b < N; b++)
          if (ack[b] && b != m_sel) m_spur = 1;
        if (ack[m_sel]) begin
          m_pend = 0;
          m_done = (m_done + 1) % (2**CNT_W);
        end else if (cyc == m_deadline) begin
          m_pend = 0;
          m_terr = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [N-1:0] exp_oh;
      exp_oh = m_pend ? (N'(1) << m_sel) : '0;
      total++;
      if (in_ready === !m_pend && req_valid === m_pend && req_onehot === exp_oh &&
          timeout_err === m_terr && spurious_ack === m_spur &&
          done_cnt === CNT_W'(m_done)) begin
        passed++;
      end else begin
        $display("FAIL model t=%0t: got rdy=%b v=%b oh=%b terr=%b spur=%b cnt=%0d, want rdy=%b v=%b oh=%b terr=%b spur=%b cnt=%0d",
                 $time, in_ready, req_valid, req_onehot, timeout_err, spurious_ack, done_cnt,
                 !m_pend, m_pend, exp_oh, m_terr, m_spur, m_done);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(req_valid), 32'd0);
    check("rst_onehot", 32'(req_onehot), 32'd0);
    check("rst_cnt", 32'(done_cnt), 32'd0);
    rst_n = 1'b1;

    // ack noise while idle must not raise spurious_ack
    ack = 4'b1111;
    repeat (3) @(negedge clk);
    check("idle_spur", 32'(spurious_ack), 32'd0);
    ack = '0;
    @(negedge clk);

    // single dispatch to line 2
    in_valid = 1'b1; in_idx = 2'd2;
    @(negedge clk);
    in_valid = 1'b0;
    check("single_onehot", 32'(req_onehot), 32'h4);
    check("single_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("single_ready_hold", 32'(in_ready), 32'd0);
    ack = 4'b0100;
    @(negedge clk);
    ack = '0;
    check("single_cleared", 32'(req_valid), 32'd0);
    check("single_cnt", 32'(done_cnt), 32'd1);

    // timeout on line 3
    in_valid = 1'b1; in_idx = 2'd3;
    @(negedge clk);
    in_valid = 1'b0;
    check("to_onehot", 32'(req_onehot), 32'h8);
    n = 0;
    while (req_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("to_held_cycles", 32'(n), 32'd16);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_ready", 32'(in_ready), 32'd1);
    check("to_cnt", 32'(done_cnt), 32'd1);
    @(negedge clk);
    check("to_err_pulse", 32'(timeout_err), 32'd0);

    // ack collides with timeout, plus a spurious bit
    in_valid = 1'b1; in_idx = 2'd1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("col_still_pend", 32'(req_valid), 32'd1);
    ack = 4'b0011;
    @(negedge clk);
    ack = '0;
    check("col_cnt", 32'(done_cnt), 32'd2);
    check("col_spur", 32'(spurious_ack), 32'd1);
    check("col_no_terr", 32'(timeout_err), 32'd0);
    check("col_cleared", 32'(req_valid), 32'd0);

    // back-to-back: 254 more dispatches takes the counter from 2 through 255 to 0
    for (int d = 0; d < 254; d++) begin
      in_valid = 1'b1; in_idx = 2'(d % 4); ack = '0;
      @(negedge clk);
      if (d < 4) check("b2b_onehot", 32'(req_onehot), 32'd1 << (d % 4));
      if (d == 253) check("b2b_cnt_255", 32'(done_cnt), 32'd255);
      ack = N'(1) << (d % 4);
      @(negedge clk);
    end
    in_valid = 1'b0; ack = '0;
    check("wrap_cnt", 32'(done_cnt), 32'd0);
    check("wrap_ready", 32'(in_ready), 32'd1);

    // asynchronous reset while pending on line 1
    in_valid = 1'b1; in_idx = 2'd1;
    @(negedge clk);
    in_valid = 1'b0;
    check("arst_pre", 32'(req_onehot), 32'h2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_onehot", 32'(req_onehot), 32'd0);
    check("arst_valid", 32'(req_valid), 32'd0);
    check("arst_cnt", 32'(done_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_err", 32'(timeout_err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
